regfile_nrmw_clr: RTL and testbench



---
 rtl/regfile_nrmw_clr.sv | 129 ++++++++++++
 tb/tb_regfile_nrmw_clr.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_nrmw_clr.sv
// regfile_nrmw_clr: multi-port register file with combinational reads,
// synchronous writes, highest-port-wins collisions, optional write-to-read
// bypass, optional hardwired zero entry and a self-sequencing clear engine.
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module regfile_nrmw_clr #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = `DATA_LEN,
    parameter int DEPTH      = 32,
    parameter int NUM_RD     = 4,
    parameter int NUM_WR     = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear_req,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
    input  logic [NUM_WR-1:0]            we,
    output logic                         ready,
    output logic                         clear_done
);

    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]         CNT_LAST = CW'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t  state;
    logic [CW-1:0] cnt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Packed per-port views of the flat buses
    logic [NUM_RD-1:0][ADDR_WIDTH-1:0] ra;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd;
    logic [NUM_WR-1:0][ADDR_WIDTH-1:0] wa;
    logic [NUM_WR-1:0][DATA_WIDTH-1:0] wd;
    logic [NUM_WR-1:0]                 wvalid;
    logic                              wr_en;

    assign ra    = raddr;
    assign wa    = waddr;
    assign wd    = wdata;
    assign rdata = rd;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < DEPTH_L);
    endfunction

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Writes land only in RUN with no clear/reset pending on this edge
    assign wr_en = (state == RUN) && !clear_req && !reset;

    // Qualify each write port: enabled, in range, not the hardwired zero entry
    always_comb begin
        wvalid = '0;
        for (int j = 0; j < NUM_WR; j++)
            wvalid[j] = wr_en && we[j] && in_range(wa[j]) && !is_zero(wa[j]);
    end

    // Clear sequencer: CLEAR walks cnt over every entry, then hands over to RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            cnt        <= '0;
            ready      <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                CLEAR: begin
                    if (cnt == CNT_LAST) begin
                        state      <= RUN;
                        ready      <= 1'b1;
                        clear_done <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (clear_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Array update: zero one entry per CLEAR cycle, else apply writes in port
    // order so the highest-index port wins a collision
    always_ff @(posedge clk) begin
        if (!reset && state == CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++)
                if (wvalid[j])
                    mem[wa[j][CW-1:0]] <= wd[j];
        end
    end

    // Combinational read with optional same-cycle bypass (last match wins)
    always_comb begin
        rd = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (state == RUN && in_range(ra[i]) && !is_zero(ra[i])) begin
                rd[i] = mem[ra[i][CW-1:0]];
                if (BYPASS != 0)
                    for (int j = 0; j < NUM_WR; j++)
                        if (wvalid[j] && wa[j] == ra[i])
                            rd[i] = wd[j];
            end
        end
    end

endmodule

// File: tb/tb_regfile_nrmw_clr.sv
// Bench for regfile_nrmw_clr: two instances (32 entries with bypass, and
// 24 entries without bypass), both with a hardwired zero entry, driven by
// the same stimulus and checked against an array-based reference model.
module tb_regfile_nrmw_clr;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int NW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, clear_req;
    logic [NR*AW-1:0]  raddr;
    logic [NW*AW-1:0]  waddr;
    logic [NW*DW-1:0]  wdata;
    logic [NW-1:0]     we;
    logic [NR*DW-1:0]  rdata0, rdata1;
    logic              ready0, ready1, done0, done1;

    int checks = 0;
    int errors = 0;

    regfile_nrmw_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(32), .NUM_RD(NR),
                       .NUM_WR(NW), .BYPASS(1), .ZERO_REG(1)) u0 (
        .clk(clk), .reset(reset), .clear_req(clear_req), .raddr(raddr), .rdata(rdata0),
        .waddr(waddr), .wdata(wdata), .we(we), .ready(ready0), .clear_done(done0));

    regfile_nrmw_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(24), .NUM_RD(NR),
                       .NUM_WR(NW), .BYPASS(0), .ZERO_REG(1)) u1 (
        .clk(clk), .reset(reset), .clear_req(clear_req), .raddr(raddr), .rdata(rdata1),
        .waddr(waddr), .wdata(wdata), .we(we), .ready(ready1), .clear_done(done1));

    // Reference model: per instance, an array plus "edges left to clear"
    int          depth [2] = '{32, 24};
    int          byp   [2] = '{1, 0};
    int          zr    [2] = '{1, 1};
    logic [31:0] mm    [2][32];
    bit          rdy   [2];
    bit          dn    [2];
    int          left  [2];
    bit          rnd_w;

    function automatic int wa_of(int j);
        return int'(waddr[j*AW +: AW]);
    endfunction

    function automatic bit wok(int k, int j);
        int a = wa_of(j);
        return we[j] && a < depth[k] && !(zr[k] != 0 && a == 0);
    endfunction

    function automatic logic [31:0] exp_rd(int k, int i);
        int a = int'(raddr[i*AW +: AW]);
        logic [31:0] v;
        if (!rdy[k] || a >= depth[k] || (zr[k] != 0 && a == 0)) return 32'd0;
        v = mm[k][a];
        if (byp[k] != 0 && !clear_req && !reset)
            for (int j = 0; j < NW; j++)
                if (wok(k, j) && wa_of(j) == a) v = wdata[j*DW +: DW];
        return v;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                rdy[k] = 0; dn[k] = 0; left[k] = depth[k];
            end else if (!rdy[k]) begin
                mm[k][depth[k] - left[k]] = 32'd0;
                left[k]--;
                dn[k] = 0;
                if (left[k] == 0) begin rdy[k] = 1; dn[k] = 1; end
            end else begin
                dn[k] = 0;
                if (clear_req) begin
                    rdy[k] = 0; left[k] = depth[k];
                end else begin
                    for (int j = 0; j < NW; j++)
                        if (wok(k, j)) mm[k][wa_of(j)] = wdata[j*DW +: DW];
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [NR*DW-1:0] e0, e1;
        for (int i = 0; i < NR; i++) begin
            e0[i*DW +: DW] = exp_rd(0, i);
            e1[i*DW +: DW] = exp_rd(1, i);
        end
        chk("ready0", 128'(ready0), 128'(rdy[0]));
        chk("ready1", 128'(ready1), 128'(rdy[1]));
        chk("done0",  128'(done0),  128'(dn[0]));
        chk("done1",  128'(done1),  128'(dn[1]));
        chk("rdata0", 128'(rdata0), 128'(e0));
        chk("rdata1", 128'(rdata1), 128'(e1));
    endtask

    task automatic rand_writes();
        we    = NW'($urandom);
        waddr = (NW*AW)'($urandom);
        wdata = {$urandom, $urandom};
    endtask

    // One clock: check combinational/registered outputs at negedge, then edge
    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic setw(int j, bit en, int a, logic [31:0] d);
        we[j]              = en;
        waddr[j*AW +: AW]  = AW'(a);
        wdata[j*DW +: DW]  = d;
    endtask

    task automatic setr_all(int a);
        for (int i = 0; i < NR; i++) raddr[i*AW +: AW] = AW'(a);
    endtask

    task automatic wait_ready(input string tag, input int exp);
        int n = 0;
        while (!ready0 && n < 100) begin
            if (rnd_w) rand_writes();
            tick();
            n++;
        end
        chk(tag, 128'(n), 128'(exp));
    endtask

    // Read every address (rotated across ports); optionally demand all zero
    task automatic sweep(input bit want_zero);
        for (int a = 0; a < 32; a++) begin
            for (int i = 0; i < NR; i++) raddr[i*AW +: AW] = AW'((a + i) % 32);
            #1;
            if (want_zero) chk("sweep_zero", 128'(rdata0), 128'(0));
            tick();
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 32; a++) mm[k][a] = 32'd0;
        rnd_w = 0;
        reset = 1; clear_req = 0; raddr = '0; waddr = '0; wdata = '0; we = '0;
        @(posedge clk); model_edge(); #1;
        reset = 0;
        chk("reset_ready", 128'(ready0), 128'(0));
        chk("reset_rdata", 128'(rdata0), 128'(0));

        // Clear sequencing after a one-cycle reset
        wait_ready("clear_latency", 32);
        chk("done_pulse", 128'(done0), 128'(1));
        tick();
        chk("done_fall", 128'(done0), 128'(0));
        sweep(1);

        // Basic write/read: bypass instance sees it now, the other next cycle
        setw(0, 1, 5, 32'hDEADBEEF); setr_all(5); #1;
        chk("byp_same", 128'(rdata0), 128'({4{32'hDEADBEEF}}));
        chk("nobyp_same", 128'(rdata1), 128'(0));
        tick();
        we = '0; #1;
        chk("nobyp_next", 128'(rdata1), 128'({4{32'hDEADBEEF}}));
        chk("byp_next", 128'(rdata0), 128'({4{32'hDEADBEEF}}));

        // Collision: highest port wins, also on the bypass path
        setw(0, 1, 7, 32'h11); setw(1, 1, 7, 32'h22); setr_all(7); #1;
        chk("coll_byp", 128'(rdata0), 128'({4{32'h22}}));
        tick();
        we = '0; #1;
        chk("coll_mem0", 128'(rdata0), 128'({4{32'h22}}));
        chk("coll_mem1", 128'(rdata1), 128'({4{32'h22}}));

        // Zero entry and out-of-range write
        setw(0, 1, 0, 32'h55); setw(1, 1, 30, 32'h55); setr_all(0);
        tick();
        we = '0; #1;
        chk("zero_reg0", 128'(rdata0), 128'(0));
        chk("zero_reg1", 128'(rdata1), 128'(0));
        setr_all(30); #1;
        chk("oor_read1", 128'(rdata1), 128'(0));
        sweep(0);

        // Fill with index, then clear_req with a concurrent write to 3
        for (int a = 0; a < 16; a++) begin
            setw(0, 1, 2*a, 32'(2*a)); setw(1, 1, 2*a + 1, 32'(2*a + 1));
            tick();
        end
        we = '0;
        sweep(0);
        clear_req = 1; setw(0, 1, 3, 32'h99); setr_all(3); #1;
        chk("clr_no_byp", 128'(rdata0), 128'({4{32'd3}}));
        tick();
        clear_req = 0; we = '0; #1;
        chk("clr_ready_fall", 128'(ready0), 128'(0));
        wait_ready("clr_latency", 32);
        sweep(1);

        // Reset mid-clear with writes attempted throughout the clear
        clear_req = 1; tick(); clear_req = 0;
        rnd_w = 1;
        for (int c = 0; c < 10; c++) begin rand_writes(); tick(); end
        reset = 1;
        for (int c = 0; c < 3; c++) begin rand_writes(); tick(); end
        reset = 0;
        wait_ready("rst_mid_latency", 32);
        rnd_w = 0; we = '0;
        sweep(1);

        // Randomized traffic with occasional clear requests and resets
        for (int c = 0; c < 600; c++) begin
            rand_writes();
            raddr     = (NR*AW)'($urandom);
            clear_req = ($urandom_range(0, 63) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 0; clear_req = 0; we = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global safety net against a hung run
    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
